sprite_mem_arbiter: RTL and testbench
=====================================

// Module: sprite_mem_arbiter
// PURPOSE
//  Shares the single read port of the on-chip sprite/background ROM between N_REQ pixel-layer requesters:
//  req 0 = background address generator, 1-2 = player sprites, 3 = overlay/HUD.
//  Round-robin grant, one read issued per clock, fixed-latency pipelined return routed back by tag.
//  Sits between the layer address generators and the ROM; color mapper consumes the returned data.
// PARAMETERS
//  N_REQ      4        number of requesters (2..8)
//  ADDR_W     18       ROM word address width
//  DATA_W     8        ROM word (palette index) width
//  MEM_DEPTH  155307   valid ROM words; addresses >= MEM_DEPTH are out of range
//  MEM_LAT    2        ROM read latency, cycles from mem_rd to valid mem_rdata (>=1)
// PORTS
//  Clk        in   1                 system clock (50 MHz pixel domain)
//  Reset_n    in   1                 asynchronous active-low reset
//  arb_en     in   1                 1 = grants allowed; 0 = freeze new grants
//  req        in   N_REQ             per-requester read request, held until gnt
//  addr       in   N_REQ*ADDR_W      flattened addresses; slice i = addr[i*ADDR_W +: ADDR_W]
//  gnt        out  N_REQ             one-hot grant, combinational, same cycle as accepted req
//  rvalid     out  N_REQ             one-hot read-return strobe, registered
//  rdata      out  DATA_W            return data, valid where any rvalid bit = 1
//  rerr       out  1                 pulses with rvalid when the read was out of range
//  busy       out  1                 1 while any read is in flight
//  mem_rd     out  1                 registered ROM read strobe
//  mem_addr   out  ADDR_W            registered ROM address
//  mem_rdata  in   DATA_W            ROM data, MEM_LAT cycles after mem_rd
// BEHAVIOUR
//  Reset (async assert, sync release): gnt=0, rvalid=0, rdata=0, rerr=0, busy=0, mem_rd=0,
//   mem_addr=0, rr pointer=0, tag pipe cleared; in-flight reads are discarded, never returned.
//  Arbitration: if arb_en & |req, winner = first req[i] set searching from pointer upward, wrapping.
//   gnt[winner]=1 same cycle; pointer <= winner+1 (mod N_REQ) at next edge. No req or arb_en=0: gnt=0, pointer held.
//  Handshake: requester keeps req/addr stable until gnt; transfer occurs on the edge where req&gnt.
//   Requester may keep req high for a new address the next cycle; 1 read/cycle sustained throughput.
//  Issue (edge after grant, cycle t+1): in-range addr -> mem_rd=1, mem_addr=addr[winner];
//   out-of-range addr -> mem_rd=0, mem_addr unchanged, read still tagged as error. No grant -> mem_rd=0.
//  Tag pipe: depth 1+MEM_LAT, entries {valid, id[$clog2(N_REQ)-1:0], err}; shifts every cycle.
//  Return at t+1+MEM_LAT (3 cycles after gnt by default): rvalid[id]=1 for one cycle,
//   rdata=mem_rdata (err=0) or 0 with rerr=1 (err=1). No valid tag -> rvalid=0, rerr=0, rdata holds.
//  Order: returns per requester and globally in grant order; at most one rvalid bit per cycle.
//  arb_en falling mid-stream: no new grants; in-flight tags complete normally; busy reflects pipe.
//  busy = OR of tag-pipe valid bits (registered state, no combinational path from req).
//  Width: range check is addr < MEM_DEPTH on full ADDR_W unsigned compare; no truncation.
// STRUCTURE
//  Package sprite_mem_pkg: ADDR_W, DATA_W, MEM_DEPTH, N_REQ, requester index constants
//   (REQ_BG=0, REQ_P0=1, REQ_P1=2, REQ_HUD=3), map base offsets MAP0_BASE=1707, MAP1_BASE=78507,
//   tag struct typedef rd_tag_t.
//  Sub-module rr_arbiter (N): combinational req+pointer -> one-hot gnt + encoded winner id.
//  Top: pointer register, issue register, tag shift pipe, return demux.
// TESTING
//  1 Single req[0], addr=1707, ROM[1707]=0x3C -> gnt[0] same cycle, mem_rd=1 mem_addr=1707 next cycle,
//    rvalid=4'b0001 rdata=0x3C exactly 3 cycles after gnt, rerr=0.
//  2 req=4'b1111 held 8 cycles, arb_en=1 -> gnt sequence 0,1,2,3,0,1,2,3; rvalid same order, lag 3.
//  3 req[2] addr=200000 -> gnt[2], mem_rd stays 0, 3 cycles later rvalid=4'b0100, rerr=1, rdata=0.
//  4 Two reads in flight, then arb_en=0 with req=4'b0011 -> gnt=0, both rvalids arrive, busy falls to 0.
//  5 Two reads in flight, Reset_n low 1 cycle mid-pipe -> all outputs 0 immediately, no rvalid after
//    release, next grant search starts at req 0.
//  6 req[1] only, new addr each cycle 78507..78514 -> gnt[1] every cycle, 8 consecutive rvalid[1],
//    rdata matches ROM in order.

Source files
------------

// File: rtl/sprite_mem_arbiter_pkg.sv
// sprite_mem_pkg: shared sizes, requester ids, map bases and the read-tag record for the sprite ROM arbiter
package sprite_mem_pkg;
  localparam int N_REQ = 4;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int MEM_DEPTH = 155307;
  localparam int MEM_LAT = 2;
  localparam int ID_W = $clog2(N_REQ);
  localparam int REQ_BG = 0;
  localparam int REQ_P0 = 1;
  localparam int REQ_P1 = 2;
  localparam int REQ_HUD = 3;
  localparam int MAP0_BASE = 1707;
  localparam int MAP1_BASE = 78507;
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
    logic err;
  } rd_tag_t;
endpackage

// File: rtl/sprite_mem_arbiter_if.sv
// sprite_mem_arbiter_if: requester-side handshake plus ROM read port of the sprite arbiter
interface sprite_mem_arbiter_if;
  import sprite_mem_pkg::*;
  logic arb_en;
  logic [N_REQ-1:0] req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rvalid;
  logic [DATA_W-1:0] rdata;
  logic rerr;
  logic busy;
  logic mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output arb_en, req, addr, mem_rdata, input gnt, rvalid, rdata, rerr, busy, mem_rd, mem_addr);
  modport slave (input arb_en, req, addr, mem_rdata, output gnt, rvalid, rdata, rerr, busy, mem_rd, mem_addr);
endinterface

// File: rtl/sprite_mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above the pointer wins
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] id
);
  always_comb begin
    gnt = '0;
    id = '0;
    for (int k = N - 1; k >= 0; k--)
      if (en && req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        id = W'((int'(ptr) + k) % N);
      end
  end
endmodule

// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter: round-robin share of the sprite ROM read port with tagged fixed-latency returns
module sprite_mem_arbiter
  import sprite_mem_pkg::*;
(
  input logic Clk,
  input logic Reset_n,
  sprite_mem_arbiter_if.slave bus
);
  logic [ID_W-1:0] ptr, winId;
  logic [N_REQ-1:0] gntW;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] heldData, rdataW;
  logic inRange, anyGnt, busyW;
  rd_tag_t tagPipe [MEM_LAT+1];
  rd_tag_t retTag;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(bus.req),
    .ptr(ptr),
    .en(bus.arb_en & Reset_n),
    .gnt(gntW),
    .id(winId)
  );
  assign anyGnt = |gntW;
  assign winAddr = bus.addr[int'(winId)*ADDR_W +: ADDR_W];
  assign inRange = winAddr < ADDR_W'(MEM_DEPTH);
  assign retTag = tagPipe[MEM_LAT];
  // the tag at the pipe tail lines up with mem_rdata, so data passes straight through on return
  assign rdataW = retTag.valid ? (retTag.err ? '0 : bus.mem_rdata) : heldData;
  assign bus.gnt = gntW;
  assign bus.rdata = rdataW;
  assign bus.rvalid = retTag.valid ? N_REQ'(1) << retTag.id : '0;
  assign bus.rerr = retTag.valid & retTag.err;
  assign bus.busy = busyW;
  always_comb begin
    busyW = 1'b0;
    for (int i = 0; i <= MEM_LAT; i++) busyW = busyW | tagPipe[i].valid;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      ptr <= '0;
      bus.mem_rd <= 1'b0;
      bus.mem_addr <= '0;
      heldData <= '0;
      for (int i = 0; i <= MEM_LAT; i++) tagPipe[i] <= '0;
    end else begin
      ptr <= anyGnt ? (winId == ID_W'(N_REQ - 1) ? '0 : winId + 1'b1) : ptr;
      bus.mem_rd <= anyGnt & inRange;
      if (anyGnt && inRange) bus.mem_addr <= winAddr;
      tagPipe[0] <= '{valid: anyGnt, id: winId, err: !inRange};
      for (int i = 1; i <= MEM_LAT; i++) tagPipe[i] <= tagPipe[i-1];
      if (retTag.valid) heldData <= rdataW;
    end
endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// tb_sprite_mem_arbiter: directed and random traffic against a queue-based model of grants and returns
module tb_sprite_mem_arbiter;
  import sprite_mem_pkg::*;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #10 Clk = ~Clk;
  sprite_mem_arbiter_if bus();
  sprite_mem_arbiter dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  logic [DATA_W-1:0] rom [MEM_DEPTH];
  logic romRd [MEM_LAT];
  logic [ADDR_W-1:0] romAddr [MEM_LAT];
  always @(posedge Clk) begin
    romRd[0] <= bus.mem_rd;
    romAddr[0] <= bus.mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      romRd[i] <= romRd[i-1];
      romAddr[i] <= romAddr[i-1];
    end
  end
  assign bus.mem_rdata = (romRd[MEM_LAT-1] === 1'b1 && romAddr[MEM_LAT-1] < ADDR_W'(MEM_DEPTH))
                         ? rom[romAddr[MEM_LAT-1]] : 8'hEE;

  typedef struct {
    int due;
    int id;
    logic err;
    logic [DATA_W-1:0] data;
  } ret_t;
  ret_t q[$];
  int gLog[$];
  int ptr, cyc, nCmp, nBad, lastWin;
  logic [DATA_W-1:0] held;
  logic expRd;
  logic [ADDR_W-1:0] expAddr;
  logic [N_REQ-1:0] reqV;
  logic [ADDR_W-1:0] a [N_REQ];
  logic en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] pick();
    case ($urandom_range(5))
      0: return ADDR_W'(MEM_DEPTH - 1);
      1: return ADDR_W'(MEM_DEPTH);
      2: return '1;
      3: return ADDR_W'(MAP0_BASE + $urandom_range(500));
      default: return ADDR_W'($urandom_range(MEM_DEPTH - 1));
    endcase
  endfunction

  // one clock: drive inputs, check everything against the model, then advance the model over the edge
  task automatic tick();
    int win;
    logic inR;
    logic [N_REQ-1:0] eg, erv;
    logic [DATA_W-1:0] ed;
    logic ee;
    bus.req = reqV;
    bus.arb_en = en;
    for (int i = 0; i < N_REQ; i++) bus.addr[i*ADDR_W +: ADDR_W] = a[i];
    #1;
    if (!Reset_n) begin
      ptr = 0;
      q.delete();
      held = '0;
      expRd = 1'b0;
      expAddr = '0;
    end
    win = -1;
    if (Reset_n && en)
      for (int k = 0; k < N_REQ; k++)
        if (win < 0 && reqV[(ptr + k) % N_REQ]) win = (ptr + k) % N_REQ;
    eg = (win < 0) ? '0 : N_REQ'(1) << win;
    erv = '0;
    ed = held;
    ee = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      erv = N_REQ'(1) << q[0].id;
      ee = q[0].err;
      ed = ee ? '0 : q[0].data;
    end
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("rvalid", 32'(bus.rvalid), 32'(erv));
    chk("rdata", 32'(bus.rdata), 32'(ed));
    chk("rerr", 32'(bus.rerr), 32'(ee));
    chk("busy", 32'(bus.busy), 32'(q.size() > 0));
    chk("mem_rd", 32'(bus.mem_rd), 32'(expRd));
    chk("mem_addr", 32'(bus.mem_addr), 32'(expAddr));
    if (erv != 0) begin
      held = ed;
      void'(q.pop_front());
    end
    lastWin = win;
    expRd = 1'b0;
    if (win >= 0) begin
      inR = a[win] < ADDR_W'(MEM_DEPTH);
      gLog.push_back(win);
      q.push_back('{cyc + 1 + MEM_LAT, win, !inR, inR ? rom[a[win]] : 8'h00});
      expRd = inR;
      if (inR) expAddr = a[win];
      ptr = (win + 1) % N_REQ;
    end
    cyc++;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    nCmp = 0;
    nBad = 0;
    cyc = 0;
    for (int i = 0; i < MEM_DEPTH; i++) rom[i] = DATA_W'($urandom);
    rom[MAP0_BASE] = 8'h3C;
    for (int i = 0; i < MEM_LAT; i++) begin
      romRd[i] = 1'b0;
      romAddr[i] = '0;
    end
    for (int i = 0; i < N_REQ; i++) a[i] = '0;
    reqV = '1;
    en = 1'b1;
    @(negedge Clk);
    tick();
    tick();
    Reset_n = 1'b1;
    reqV = '0;
    tick();

    // all four requesting: pure rotation from pointer 0
    gLog.delete();
    reqV = 4'b1111;
    for (int i = 0; i < N_REQ; i++) a[i] = ADDR_W'(MAP1_BASE + i);
    repeat (8) tick();
    reqV = '0;
    repeat (4) tick();
    for (int k = 0; k < 8; k++) chk("t2_order", 32'(gLog[k]), 32'(k % 4));

    // single background read of a known ROM word
    reqV = 4'b0001;
    a[REQ_BG] = ADDR_W'(MAP0_BASE);
    tick();
    reqV = '0;
    chk("t1_memrd", 32'(bus.mem_rd), 32'd1);
    chk("t1_memaddr", 32'(bus.mem_addr), 32'(MAP0_BASE));
    tick();
    tick();
    chk("t1_rvalid", 32'(bus.rvalid), 32'h1);
    chk("t1_rdata", 32'(bus.rdata), 32'h3C);
    repeat (2) tick();

    // out-of-range read never touches the ROM but still returns an error
    reqV = 4'b0100;
    a[REQ_P1] = ADDR_W'(200000);
    tick();
    reqV = '0;
    chk("t3_memrd", 32'(bus.mem_rd), 32'd0);
    tick();
    tick();
    chk("t3_rvalid", 32'(bus.rvalid), 32'h4);
    chk("t3_rerr", 32'(bus.rerr), 32'd1);
    chk("t3_rdata", 32'(bus.rdata), 32'd0);
    repeat (2) tick();

    // freeze grants with reads in flight
    reqV = 4'b0011;
    a[0] = ADDR_W'(100);
    a[1] = ADDR_W'(MEM_DEPTH - 1);
    tick();
    tick();
    en = 1'b0;
    repeat (5) tick();
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_gnt", 32'(bus.gnt), 32'd0);
    en = 1'b1;
    reqV = '0;

    // back-to-back reads from one player sprite
    reqV = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      a[REQ_P0] = ADDR_W'(MAP1_BASE + k);
      tick();
    end
    reqV = '0;
    repeat (4) tick();

    // reset with reads in flight: they vanish and the pointer restarts at 0
    reqV = 4'b1111;
    for (int i = 0; i < N_REQ; i++) a[i] = pick();
    tick();
    tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    reqV = '0;
    repeat (4) tick();
    reqV = 4'b1111;
    tick();
    chk("t5_first", 32'(lastWin), 32'd0);
    reqV = '0;
    repeat (4) tick();

    repeat (400) begin
      for (int i = 0; i < N_REQ; i++)
        if (!reqV[i] && $urandom_range(2) == 0) begin
          reqV[i] = 1'b1;
          a[i] = pick();
        end
      en = $urandom_range(7) != 0;
      tick();
      if (lastWin >= 0) begin
        reqV[lastWin] = 1'($urandom_range(1));
        a[lastWin] = pick();
      end
    end
    reqV = '0;
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
